spi_write_decoder: RTL and testbench
====================================

// Module: spi_write_decoder
// PURPOSE
//  Consumes the byte stream of the SPI slave (rx_data/rx_valid/rx_start) and turns framed SPI
//  writes into register-bank write strobes. First byte of a frame is a command (write flag +
//  start address); following bytes are assembled MSB-first into DATA_W-bit words. Each word is
//  written to an auto-incrementing address. Sits between spi_slave and the pulse-control registers.
// PARAMETERS
//  DATA_W  16  register word width; multiple of 8, 8..32; BYTES = DATA_W/8
//  ADDR_W  4   register address width, 1..7
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  rx_data    in   8       byte from spi_slave, valid when rx_valid=1
//  rx_valid   in   1       1-cycle strobe: rx_data holds a complete byte
//  rx_start   in   1       1-cycle strobe: nCS asserted, new frame begins
//  wr_en      out  1       1-cycle write strobe
//  wr_addr    out  ADDR_W  write address, held between strobes
//  wr_data    out  DATA_W  write data, held between strobes
//  err_cmd    out  1       1-cycle pulse: command byte with bit7=0 (unsupported)
//  err_short  out  1       1-cycle pulse: frame ended with partial word pending
//  busy       out  1       1 while in CMD or DATA state
// BEHAVIOUR
//  - Reset: state=IDLE; wr_en, err_cmd, err_short, busy = 0; wr_addr, wr_data = 0; byte_cnt = 0.
//    Reset asserted mid-frame abandons the frame; no write or error pulse is produced.
//  - States: IDLE, CMD, DATA, DISCARD. All outputs registered.
//  - IDLE: rx_valid ignored. rx_start -> CMD.
//  - CMD: rx_valid with rx_data[7]=1 -> addr_ptr <= rx_data[ADDR_W-1:0] (bits 6:ADDR_W ignored),
//    byte_cnt <= 0, -> DATA. With rx_data[7]=0 -> err_cmd pulses the next cycle, -> DISCARD.
//  - DATA: each rx_valid shifts rx_data into the accumulator (acc <= {acc, rx_data}), byte_cnt++.
//    The byte completing a word (byte_cnt == BYTES-1) triggers, on the next clock edge:
//    wr_en=1, wr_data=completed word, wr_addr=addr_ptr. In the same edge addr_ptr increments
//    mod 2^ADDR_W (wraps 2^ADDR_W-1 -> 0) and byte_cnt clears.
//    Latency is 1 clk from the final rx_valid to wr_en.
//  - DISCARD: rx_valid ignored until the next rx_start.
//  - Frame end: there is no nCS-deassert input; a frame ends only at the next rx_start.
//    rx_start in DATA with byte_cnt != 0 -> err_short pulses the next cycle; partial word dropped.
//    rx_start in any state -> CMD, byte_cnt cleared.
//  - Simultaneous rx_start and rx_valid: rx_start is applied first, and the byte is taken as the
//    command byte of the new frame. The short-frame check uses the old byte_cnt.
//  - DATA_W=8: every data byte produces a write. err_short can never fire.
//  - wr_en is never asserted on two consecutive cycles unless rx_valid arrives on consecutive
//    cycles with BYTES=1. No backpressure exists; the consumer accepts every strobe.
// TESTING
//  Use DATA_W=16, ADDR_W=4 unless stated.
//  1. Frame rx_start, 0x83,0x12,0x34,0xAB,0xCD -> wr(3,0x1234) then wr(4,0xABCD),
//     each 1 clk after the 2nd byte of its word; no errors.
//  2. Frame rx_start, 0x8F,0x11,0x22,0x33,0x44 -> wr(15,0x1122), wr(0,0x3344); wrap-around.
//  3. rx_start, 0x81,0x55, then rx_start -> no wr_en; err_short 1 clk after 2nd rx_start; busy=1.
//  4. rx_start, 0x05,0xAA,0xBB -> err_cmd pulse after 0x05; no wr_en. Then rx_start, 0x82,0xAA,0xBB
//     -> wr(2,0xAABB).
//  5. rx_start, 0x84,0x12, reset pulse, then rx_data 0x34 strobed -> no wr_en and no errors;
//     outputs at reset values.
//  6. Same-cycle rx_start + rx_valid(0x86) after a partial word -> err_short; then 0xDE,0xAD
//     -> wr(6,0xDEAD).
//     DATA_W=8 run: rx_start, 0x80,0x01,0x02 -> wr(0,0x01), wr(1,0x02).

Source files
------------

// File: rtl/spi_write_decoder.sv
// spi_write_decoder: turns framed SPI write bytes into register-bank write strobes
module spi_write_decoder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              err_cmd,
    output logic              err_short,
    output logic              busy
);
    localparam int BYTES = DATA_W / 8;
    localparam logic [1:0] LAST = 2'(BYTES - 1);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr_ptr, ptr_nx;
    logic [DATA_W-1:0] acc, acc_nx;
    logic [1:0] byte_cnt, cnt_nx;
    logic wr_nx, ecmd_nx, eshort_nx, cmd_take;
    // next-state: rx_start wins and a same-cycle byte becomes the new command byte
    always_comb begin
        state_nx = state;
        ptr_nx = addr_ptr;
        acc_nx = acc;
        cnt_nx = byte_cnt;
        wr_nx = 1'b0;
        ecmd_nx = 1'b0;
        eshort_nx = 1'b0;
        cmd_take = rx_valid && (rx_start || state == CMD);
        if (rx_start) begin
            eshort_nx = state == DATA && byte_cnt != 2'd0;
            cnt_nx = 2'd0;
            state_nx = CMD;
        end
        if (cmd_take) begin
            state_nx = rx_data[7] ? DATA : DISCARD;
            ecmd_nx = !rx_data[7];
            ptr_nx = rx_data[7] ? rx_data[ADDR_W-1:0] : addr_ptr;
            cnt_nx = 2'd0;
        end else if (!rx_start && state == DATA && rx_valid) begin
            acc_nx = (acc << 8) | DATA_W'(rx_data);
            wr_nx = byte_cnt == LAST;
            ptr_nx = wr_nx ? addr_ptr + 1'b1 : addr_ptr;
            cnt_nx = wr_nx ? 2'd0 : byte_cnt + 1'b1;
        end
    end
    // state and registered outputs; async reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr_ptr <= '0;
            acc <= '0;
            byte_cnt <= 2'd0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err_cmd <= 1'b0;
            err_short <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_nx;
            addr_ptr <= ptr_nx;
            acc <= acc_nx;
            byte_cnt <= cnt_nx;
            wr_en <= wr_nx;
            err_cmd <= ecmd_nx;
            err_short <= eshort_nx;
            busy <= state_nx == CMD || state_nx == DATA;
            if (wr_nx) begin
                wr_addr <= addr_ptr;
                wr_data <= acc_nx;
            end
        end
    end
endmodule

// File: tb/tb_spi_write_decoder.sv
// tb_spi_write_decoder: directed vectors for spi_write_decoder (16-bit and 8-bit words)
module tb_spi_write_decoder;
    logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, rx_start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic wr_en, err_cmd, err_short, busy;
    logic [3:0] wr_addr;
    logic [15:0] wr_data;
    logic wr_en8, err_cmd8, err_short8, busy8;
    logic [3:0] wr_addr8;
    logic [7:0] wr_data8;
    int n_chk = 0, n_pass = 0;

    spi_write_decoder #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_start(rx_start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_cmd(err_cmd), .err_short(err_short), .busy(busy)
    );
    spi_write_decoder #(.DATA_W(8), .ADDR_W(4)) dut8 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_start(rx_start),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .err_cmd(err_cmd8), .err_short(err_short8), .busy(busy8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // one clock with the given strobes, then sample 1 time unit after the edge
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        rx_start = s;
        rx_valid = v;
        rx_data = d;
        @(posedge clk);
        #1;
        rx_start = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic outs(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d,
                        input logic ec, input logic es, input logic bz);
        check({tag, ".wr_en"}, 32'(wr_en), 32'(we));
        check({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
        check({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        check({tag, ".err_cmd"}, 32'(err_cmd), 32'(ec));
        check({tag, ".err_short"}, 32'(err_short), 32'(es));
        check({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 0, 4'h0, 16'h0000, 0, 0, 0);
        reset = 1'b0;
        step(0, 1, 8'h83);
        outs("idle_ignores_valid", 0, 4'h0, 16'h0000, 0, 0, 0);
        // test 1: two words, auto-increment
        step(1, 0, 8'h00); outs("t1.start", 0, 4'h0, 16'h0000, 0, 0, 1);
        step(0, 1, 8'h83); outs("t1.cmd", 0, 4'h0, 16'h0000, 0, 0, 1);
        step(0, 1, 8'h12); outs("t1.b0", 0, 4'h0, 16'h0000, 0, 0, 1);
        step(0, 1, 8'h34); outs("t1.w0", 1, 4'h3, 16'h1234, 0, 0, 1);
        step(0, 1, 8'hAB); outs("t1.b2", 0, 4'h3, 16'h1234, 0, 0, 1);
        step(0, 1, 8'hCD); outs("t1.w1", 1, 4'h4, 16'hABCD, 0, 0, 1);
        // test 2: address wrap 15 -> 0
        step(1, 0, 8'h00); outs("t2.start", 0, 4'h4, 16'hABCD, 0, 0, 1);
        step(0, 1, 8'h8F);
        step(0, 1, 8'h11);
        step(0, 1, 8'h22); outs("t2.w0", 1, 4'hF, 16'h1122, 0, 0, 1);
        step(0, 1, 8'h33);
        step(0, 1, 8'h44); outs("t2.w1", 1, 4'h0, 16'h3344, 0, 0, 1);
        // test 3: short frame
        step(1, 0, 8'h00); outs("t3.start", 0, 4'h0, 16'h3344, 0, 0, 1);
        step(0, 1, 8'h81);
        step(0, 1, 8'h55); outs("t3.partial", 0, 4'h0, 16'h3344, 0, 0, 1);
        step(1, 0, 8'h00); outs("t3.short", 0, 4'h0, 16'h3344, 0, 1, 1);
        // test 4: unsupported command, then a good frame
        step(0, 1, 8'h05); outs("t4.errcmd", 0, 4'h0, 16'h3344, 1, 0, 0);
        step(0, 1, 8'hAA); outs("t4.disc0", 0, 4'h0, 16'h3344, 0, 0, 0);
        step(0, 1, 8'hBB); outs("t4.disc1", 0, 4'h0, 16'h3344, 0, 0, 0);
        step(1, 0, 8'h00); outs("t4.start", 0, 4'h0, 16'h3344, 0, 0, 1);
        step(0, 1, 8'h82);
        step(0, 1, 8'hAA);
        step(0, 1, 8'hBB); outs("t4.w0", 1, 4'h2, 16'hAABB, 0, 0, 1);
        // test 5: async reset mid-frame
        step(1, 0, 8'h00);
        step(0, 1, 8'h84);
        step(0, 1, 8'h12);
        reset = 1'b1;
        #1;
        outs("t5.async", 0, 4'h0, 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 1, 8'h34); outs("t5.after", 0, 4'h0, 16'h0000, 0, 0, 0);
        // test 6: rx_start and command byte in the same cycle after a partial word
        step(1, 0, 8'h00);
        step(0, 1, 8'h81);
        step(0, 1, 8'h99);
        step(1, 1, 8'h86); outs("t6.restart", 0, 4'h0, 16'h0000, 0, 1, 1);
        step(0, 1, 8'hDE); outs("t6.b0", 0, 4'h0, 16'h0000, 0, 0, 1);
        step(0, 1, 8'hAD); outs("t6.w0", 1, 4'h6, 16'hDEAD, 0, 0, 1);
        // 8-bit word instance: every byte writes, no short-frame error
        step(1, 0, 8'h00);
        check("w8.start.err_short", 32'(err_short8), 32'(0));
        check("w8.start.busy", 32'(busy8), 32'(1));
        step(0, 1, 8'h80);
        check("w8.cmd.wr_en", 32'(wr_en8), 32'(0));
        step(0, 1, 8'h01);
        check("w8.w0.wr_en", 32'(wr_en8), 32'(1));
        check("w8.w0.wr_addr", 32'(wr_addr8), 32'(0));
        check("w8.w0.wr_data", 32'(wr_data8), 32'(8'h01));
        step(0, 1, 8'h02);
        check("w8.w1.wr_en", 32'(wr_en8), 32'(1));
        check("w8.w1.wr_addr", 32'(wr_addr8), 32'(1));
        check("w8.w1.wr_data", 32'(wr_data8), 32'(8'h02));
        step(1, 0, 8'h00);
        check("w8.end.err_short", 32'(err_short8), 32'(0));
        check("w8.end.wr_en", 32'(wr_en8), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
